// File: rtl/instr_predecode_q_pkg.sv
// Opcode encodings, decoded-entry layout and decode helpers for the 4004/4040 predecoder.
package instr_predecode_q_pkg;

    localparam int PC_MAX_W = 16;

    // Canonical opcodes: one value per instruction, operand nibble cleared where it is an operand.
    typedef enum logic [7:0] {
        NOP = 8'h00, HLT = 8'h01, BBS = 8'h02, LCR = 8'h03, OR4 = 8'h04, OR5 = 8'h05,
        AN6 = 8'h06, AN7 = 8'h07, DB0 = 8'h08, DB1 = 8'h09, SB0 = 8'h0A, SB1 = 8'h0B,
        EIN = 8'h0C, DIN = 8'h0D, RPM = 8'h0E,
        JCN = 8'h10, FIM = 8'h20, SRC = 8'h21, FIN = 8'h30, JIN = 8'h31, JUN = 8'h40,
        JMS = 8'h50, INC = 8'h60, ISZ = 8'h70, ADD = 8'h80, SUB = 8'h90, LD  = 8'hA0,
        XCH = 8'hB0, BBL = 8'hC0, LDM = 8'hD0,
        WRM = 8'hE0, WMP = 8'hE1, WRR = 8'hE2, WPM = 8'hE3, WR0 = 8'hE4, WR1 = 8'hE5,
        WR2 = 8'hE6, WR3 = 8'hE7, SBM = 8'hE8, RDM = 8'hE9, RDR = 8'hEA, ADM = 8'hEB,
        RD0 = 8'hEC, RD1 = 8'hED, RD2 = 8'hEE, RD3 = 8'hEF,
        CLB = 8'hF0, CLC = 8'hF1, IAC = 8'hF2, CMC = 8'hF3, CMA = 8'hF4, RAL = 8'hF5,
        RAR = 8'hF6, TCC = 8'hF7, DAC = 8'hF8, TCS = 8'hF9, STC = 8'hFA, DAA = 8'hFB,
        KBP = 8'hFC, DCL = 8'hFD
    } opcode_t;

    typedef enum logic {
        W1 = 1'b0,
        W2 = 1'b1
    } fsm_state_t;

    typedef struct packed {
        opcode_t op;
        logic    illegal;
    } canon_t;

    typedef struct packed {
        opcode_t               op;
        logic [3:0]            opa;
        logic [7:0]            imm;
        logic [PC_MAX_W-1:0]   pc;
        logic                  two_word;
        logic                  illegal;
    } decoded_instr_t;

    function automatic logic is_two_word(input logic [7:0] b);
        return (b[7:4] == 4'h1) || (b[7:4] == 4'h4) || (b[7:4] == 4'h5) ||
               (b[7:4] == 4'h7) || ((b[7:4] == 4'h2) && !b[0]);
    endfunction

    function automatic canon_t canon_op(input logic [7:0] b, input bit ext);
        canon_t c;
        c.op      = NOP;
        c.illegal = 1'b0;
        case (b[7:4])
            4'h0: begin
                if (b == 8'h00)                    c.op = NOP;
                else if (ext && (b != 8'h0F))      c.op = opcode_t'(b);
                else                               c.illegal = 1'b1;
            end
            4'h2, 4'h3: c.op = opcode_t'({b[7:4], 3'b000, b[0]});
            4'hE:       c.op = opcode_t'(b);
            4'hF: begin
                if (b[3:1] == 3'b111) c.illegal = 1'b1;
                else                  c.op = opcode_t'(b);
            end
            default:    c.op = opcode_t'({b[7:4], 4'h0});
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_predecode_q_sync_fifo.sv
// Synchronous FIFO with flush; the read port holds the last head once the queue drains.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (!empty) last_head <= mem[rd_ptr];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/instr_predecode_q.sv
// Predecoder: merges two-word 4004 instructions, classifies opcodes and queues decoded entries.
module instr_predecode_q
    import instr_predecode_q_pkg::*;
#(
    parameter int QDEPTH   = 2,
    parameter int PC_W     = 12,
    parameter bit EXT_4040 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [7:0]      fetch_byte_i,
    input  logic [PC_W-1:0] fetch_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output opcode_t         op_o,
    output logic [3:0]      opa_o,
    output logic [7:0]      imm_o,
    output logic [PC_W-1:0] pc_o,
    output logic            two_word_o,
    output logic            illegal_o,
    output fsm_state_t      dbg_state
);
    // Handshake: a byte moves when fetch_valid_i & fetch_ready_o at a rising edge;
    // the head entry leaves when instr_valid_o & instr_ready_i at a rising edge.

    fsm_state_t     state, state_nxt;
    logic [7:0]     first_q;
    logic [PC_W-1:0] pc_q;
    logic           full, empty, accept, push, latch_first;
    canon_t         c_single, c_pair;
    decoded_instr_t entry, head;
    logic           unused_pc_bits;

    assign fetch_ready_o = !full;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign dbg_state     = state;

    always_comb begin
        state_nxt   = state;
        push        = 1'b0;
        latch_first = 1'b0;
        entry       = '0;
        c_single    = canon_op(fetch_byte_i, EXT_4040);
        c_pair      = canon_op(first_q, EXT_4040);
        case (state)
            W1: begin
                if (accept) begin
                    if (is_two_word(fetch_byte_i)) begin
                        latch_first = 1'b1;
                        state_nxt   = W2;
                    end else begin
                        push          = 1'b1;
                        entry.op      = c_single.op;
                        entry.opa     = fetch_byte_i[3:0];
                        entry.pc      = PC_MAX_W'(fetch_pc_i);
                        entry.illegal = c_single.illegal;
                    end
                end
            end
            W2: begin
                if (accept) begin
                    push           = 1'b1;
                    entry.op       = c_pair.op;
                    entry.opa      = first_q[3:0];
                    entry.imm      = fetch_byte_i;
                    entry.pc       = PC_MAX_W'(pc_q);
                    entry.two_word = 1'b1;
                    entry.illegal  = c_pair.illegal;
                    state_nxt      = W1;
                end
            end
            default: state_nxt = W1;
        endcase
        // Flush drops the partial word and whatever was accepted alongside it.
        if (flush_i) begin
            state_nxt   = W1;
            push        = 1'b0;
            latch_first = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= W1;
            first_q <= '0;
            pc_q    <= '0;
        end else begin
            state <= state_nxt;
            if (latch_first) begin
                first_q <= fetch_byte_i;
                pc_q    <= fetch_pc_i;
            end
        end
    end

    sync_fifo #(
        .WIDTH($bits(decoded_instr_t)),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_i),
        .push  (push),
        .din   (entry),
        .pop   (instr_ready_i),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign instr_valid_o  = !empty;
    assign op_o           = head.op;
    assign opa_o          = head.opa;
    assign imm_o          = head.imm;
    assign pc_o           = head.pc[PC_W-1:0];
    assign two_word_o     = head.two_word;
    assign illegal_o      = head.illegal;
    assign unused_pc_bits = ^head.pc;

endmodule

// File: tb/tb_instr_predecode_q.sv
// Directed bench for instr_predecode_q: decode, two-word merge, back-pressure, flush and reset.
module tb_instr_predecode_q;
    import instr_predecode_q_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [7:0]  fetch_byte_i = '0;
    logic [11:0] fetch_pc_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        instr_ready_i = 1'b0;

    logic        fetch_ready_o, instr_valid_o, two_word_o, illegal_o;
    logic [7:0]  op_o, imm_o;
    logic [3:0]  opa_o;
    logic [11:0] pc_o;
    fsm_state_t  dbg_state;

    logic        x_fetch_ready, x_instr_valid, x_two_word, x_illegal;
    logic [7:0]  x_op, x_imm;
    logic [3:0]  x_opa;
    logic [11:0] x_pc;
    fsm_state_t  x_state;

    logic [33:0] head_vec;
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    assign head_vec = {op_o, opa_o, imm_o, pc_o, two_word_o, illegal_o};

    always #5 clk = ~clk;

    instr_predecode_q #(.QDEPTH(2), .PC_W(12), .EXT_4040(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .fetch_byte_i(fetch_byte_i), .fetch_pc_i(fetch_pc_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .op_o(op_o), .opa_o(opa_o), .imm_o(imm_o), .pc_o(pc_o),
        .two_word_o(two_word_o), .illegal_o(illegal_o), .dbg_state(dbg_state)
    );

    instr_predecode_q #(.QDEPTH(2), .PC_W(12), .EXT_4040(1'b1)) dut_ext (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .fetch_byte_i(fetch_byte_i), .fetch_pc_i(fetch_pc_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(x_fetch_ready),
        .instr_valid_o(x_instr_valid), .instr_ready_i(instr_ready_i),
        .op_o(x_op), .opa_o(x_opa), .imm_o(x_imm), .pc_o(x_pc),
        .two_word_o(x_two_word), .illegal_o(x_illegal), .dbg_state(x_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [7:0] op, input logic [3:0] opa,
                                       input logic [7:0] imm, input logic [11:0] pc,
                                       input logic tw, input logic il);
        return {op, opa, imm, pc, tw, il};
    endfunction

    // Offers one byte starting just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] b, input logic [11:0] pc);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        fetch_byte_i  = b;
        fetch_pc_i    = pc;
        fetch_valid_i = 1'b1;
        @(negedge clk);
        while (!fetch_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
    endtask

    task automatic check_head(input string tag);
        logic [33:0] e;
        @(negedge clk);
        check({tag, "_valid"}, instr_valid_o, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check(tag, head_vec, e);
    endtask

    task automatic pop();
        instr_ready_i = 1'b1;
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", fetch_ready_o, 1'b1);
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_head", head_vec, '0);
        check("rst_state", dbg_state, W1);
        #5 rst_n = 1'b1;

        // Single-word bytes: LDM 5, IAC, illegal FE
        send(8'hD5, 12'h010);
        exp_q.push_back(mk(8'hD0, 4'h5, 8'h00, 12'h010, 1'b0, 1'b0));
        check_head("ldm");
        pop();
        @(negedge clk);
        check("hold_empty_valid", instr_valid_o, 1'b0);
        check("hold_empty_op", op_o, 8'hD0);
        send(8'hF2, 12'h011);
        exp_q.push_back(mk(8'hF2, 4'h2, 8'h00, 12'h011, 1'b0, 1'b0));
        check_head("iac");
        pop();
        send(8'hFE, 12'h012);
        exp_q.push_back(mk(8'h00, 4'hE, 8'h00, 12'h012, 1'b0, 1'b1));
        check_head("fe_illegal");
        pop();

        // Two-word JUN
        send(8'h4A, 12'h100);
        @(negedge clk);
        check("jun_first_novalid", instr_valid_o, 1'b0);
        check("jun_first_state", dbg_state, W2);
        send(8'h3C, 12'h101);
        exp_q.push_back(mk(8'h40, 4'hA, 8'h3C, 12'h100, 1'b1, 1'b0));
        check_head("jun");
        check("jun_state", dbg_state, W1);
        pop();

        // Back-pressure with a full queue
        send(8'h60, 12'h200);
        exp_q.push_back(mk(8'h60, 4'h0, 8'h00, 12'h200, 1'b0, 1'b0));
        send(8'h81, 12'h201);
        exp_q.push_back(mk(8'h80, 4'h1, 8'h00, 12'h201, 1'b0, 1'b0));
        fetch_byte_i  = 8'hB2;
        fetch_pc_i    = 12'h202;
        fetch_valid_i = 1'b1;
        check_head("full_head_inc");
        check("full_ready", fetch_ready_o, 1'b0);
        pop();
        @(negedge clk);
        check("after_pop_ready", fetch_ready_o, 1'b1);
        check("after_pop_valid", instr_valid_o, 1'b1);
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        exp_q.push_back(mk(8'hB0, 4'h2, 8'h00, 12'h202, 1'b0, 1'b0));
        check_head("full_add");
        check("refill_ready", fetch_ready_o, 1'b0);
        pop();
        check_head("full_xch");
        pop();

        // Flush with a queued entry and a half-received FIM
        send(8'hD1, 12'h2FF);
        send(8'h22, 12'h300);
        @(negedge clk);
        check("fim_first_state", dbg_state, W2);
        @(posedge clk);
        #1;
        fetch_byte_i  = 8'h55;
        fetch_pc_i    = 12'h301;
        fetch_valid_i = 1'b1;
        flush_i       = 1'b1;
        @(posedge clk);
        #1;
        fetch_valid_i = 1'b0;
        flush_i       = 1'b0;
        @(negedge clk);
        check("flush_valid", instr_valid_o, 1'b0);
        check("flush_state", dbg_state, W1);
        send(8'h23, 12'h302);
        exp_q.push_back(mk(8'h21, 4'h3, 8'h00, 12'h302, 1'b0, 1'b0));
        check_head("src");
        pop();

        // 4040 extension byte
        send(8'h01, 12'h400);
        exp_q.push_back(mk(8'h00, 4'h1, 8'h00, 12'h400, 1'b0, 1'b1));
        check_head("ext_off_01");
        check("ext_on_op", x_op, 8'h01);
        check("ext_on_illegal", x_illegal, 1'b0);
        check("ext_on_valid", x_instr_valid, 1'b1);
        pop();

        // Reset mid two-word instruction
        send(8'h4A, 12'h500);
        @(negedge clk);
        check("mid_w2_state", dbg_state, W2);
        rst_n = 1'b0;
        #1;
        check("rst_w2_state", dbg_state, W1);
        check("rst_w2_ready", fetch_ready_o, 1'b1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_w2_release_state", dbg_state, W1);

        // Reset with a full queue
        send(8'h60, 12'h510);
        send(8'h61, 12'h511);
        @(negedge clk);
        check("prefull_ready", fetch_ready_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_full_valid", instr_valid_o, 1'b0);
        check("rst_full_ready", fetch_ready_o, 1'b1);
        check("rst_full_head", head_vec, '0);
        #2 rst_n = 1'b1;
        exp_q.delete();
        send(8'hD7, 12'h600);
        exp_q.push_back(mk(8'hD0, 4'h7, 8'h00, 12'h600, 1'b0, 1'b0));
        check_head("post_rst_ldm");
        pop();
        @(negedge clk);
        check("final_empty", instr_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
